// File: rtl/ram_bytelane.sv
// Byte-addressable data memory for the LSU: word storage with byte lanes, RV32 B/H/W
// loads and stores with extension, error reporting and a clear sweep after reset.
module ram_bytelane #(
    parameter int unsigned DEPTH_BYTES  = 256,
    parameter int unsigned ADDR_W       = $clog2(DEPTH_BYTES),
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_enm,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy_clr
);

    localparam int unsigned WORDS   = DEPTH_BYTES / 4;
    localparam int unsigned WORD_AW = ADDR_W - 2;
    localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(WORDS - 1);

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {StClear, StIdle} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WORD_AW-1:0]   r_clr_ptr;
    logic [WORD_AW-1:0]   w_clr_ptr_next;

    logic [3:0][7:0]      r_mem [WORDS];

    logic                 w_accept;
    logic                 w_err;
    logic [1:0]           w_lane;
    logic [WORD_AW-1:0]   w_word;

    logic [3:0]           w_we;
    logic [3:0][7:0]      w_wlanes;
    logic [WORD_AW-1:0]   w_waddr;

    logic [3:0][7:0]      w_rword;
    logic [7:0]           w_rbyte;
    logic [15:0]          w_rhalf;
    logic [31:0]          w_load_data;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        o_req_ready    = 1'b0;
        o_busy_clr     = 1'b0;
        unique case (r_state)
            StClear: begin
                o_busy_clr     = 1'b1;
                // Pointer wraps to 0 after the last word, leaving it ready for the next sweep.
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == LAST_WORD) begin
                    w_state_next = StIdle;
                end
            end
            StIdle: begin
                o_req_ready = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_enm) begin
            r_state   <= (CLEAR_ON_RST != 0) ? StClear : StIdle;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // ---------------------------------------------------------------- request decode
    always_comb begin
        w_accept = i_req_valid && o_req_ready;
        w_lane   = i_req_addr[1:0];
        w_word   = i_req_addr[ADDR_W-1:2];
        w_err    = 1'b0;
        unique case (i_req_size)
            SIZE_B:  w_err = 1'b0;
            SIZE_H:  w_err = i_req_addr[0];
            SIZE_W:  w_err = (i_req_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- write port
    always_comb begin
        w_we     = 4'b0000;
        w_wlanes = '0;
        w_waddr  = w_word;
        if (r_state == StClear) begin
            w_we    = 4'b1111;
            w_waddr = r_clr_ptr;
        end else if (w_accept && i_req_wr && !w_err) begin
            unique case (i_req_size)
                SIZE_B: begin
                    w_we     = 4'b0001 << w_lane;
                    w_wlanes = {4{i_req_wdata[7:0]}};
                end
                SIZE_H: begin
                    w_we     = w_lane[1] ? 4'b1100 : 4'b0011;
                    w_wlanes = {2{i_req_wdata[15:0]}};
                end
                default: begin
                    w_we     = 4'b1111;
                    w_wlanes = i_req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_enm) begin
            for (int l = 0; l < 4; l++) begin
                if (w_we[l]) begin
                    r_mem[w_waddr][l] <= w_wlanes[l];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read path
    always_comb begin
        w_rword     = r_mem[w_word];
        w_rbyte     = w_rword[w_lane];
        w_rhalf     = w_lane[1] ? {w_rword[3], w_rword[2]} : {w_rword[1], w_rword[0]};
        w_load_data = w_rword;
        unique case (i_req_size)
            SIZE_B:  w_load_data = {{24{!i_req_unsigned && w_rbyte[7]}}, w_rbyte};
            SIZE_H:  w_load_data = {{16{!i_req_unsigned && w_rhalf[15]}}, w_rhalf};
            default: w_load_data = w_rword;
        endcase
    end

    // Data and error flag hold between responses; only the valid strobe pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst_enm) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= w_err;
            o_rsp_rdata <= (w_err || i_req_wr) ? 32'h0 : w_load_data;
        end else begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_bytelane.sv
// Self-checking bench for ram_bytelane: byte-array reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_ram_bytelane;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WORDS = DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy_clr;

    always #5 clk = ~clk;

    ram_bytelane #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (8),
        .CLEAR_ON_RST(1)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_enm     (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_wr      (req_wr),
        .i_req_size    (req_size),
        .i_req_unsigned(req_unsigned),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_busy_clr    (busy_clr)
    );

    int n_checks = 0;
    int n_errs   = 0;
    bit mon_en   = 1'b0;

    // Reference model state: plain byte array plus a count of clear cycles still to run.
    logic [7:0]  m_mem [DEPTH];
    int          m_clr_left = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        int          n;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_clr_left = WORDS;
                m_valid    = 1'b0;
                m_rdata    = '0;
                m_err      = 1'b0;
            end else if (m_clr_left > 0) begin
                for (int b = 0; b < 4; b++) m_mem[(WORDS - m_clr_left) * 4 + b] = 8'h00;
                m_clr_left--;
                m_valid = 1'b0;
            end else if (req_valid) begin
                n       = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                m_valid = 1'b1;
                if (req_size == 2'd3 || (int'(req_addr) % n) != 0) begin
                    m_err   = 1'b1;
                    m_rdata = '0;
                end else if (req_wr) begin
                    for (int i = 0; i < n; i++) m_mem[int'(req_addr) + i] = req_wdata[8*i +: 8];
                    m_err   = 1'b0;
                    m_rdata = '0;
                end else begin
                    v = '0;
                    for (int i = 0; i < n; i++) v[8*i +: 8] = m_mem[int'(req_addr) + i];
                    if (n < 4 && !req_unsigned && v[8*n-1]) begin
                        for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
                    end
                    m_err   = 1'b0;
                    m_rdata = v;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("req_ready", 32'(req_ready), 32'(m_clr_left == 0));
                check("busy_clr", 32'(busy_clr), 32'(m_clr_left > 0));
                check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
                check("rsp_err", 32'(rsp_err), 32'(m_err));
                check("rsp_rdata", rsp_rdata, m_rdata);
            end
        end
    endtask

    // Drive one request at a falling edge; returns at the next falling edge with its response.
    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_wr       = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [31:0] exp_data, input logic exp_err);
        check({name, " valid"}, 32'(rsp_valid), 32'd1);
        check({name, " err"}, 32'(rsp_err), 32'(exp_err));
        check({name, " data"}, rsp_rdata, exp_data);
        check({name, " model"}, m_rdata, exp_data);
    endtask

    task automatic count_sweep(input string name);
        int cnt;
        cnt = 0;
        while (busy_clr && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check(name, cnt, 64);
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        fork
            monitor();
        join_none

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        check("ready during sweep", 32'(req_ready), 32'd0);
        count_sweep("sweep length");

        for (int w = 0; w < WORDS; w++) issue(1'b0, 2'd2, 1'b0, 8'(w * 4), 32'h0);
        lit("last word zero", 32'h0, 1'b0);
        idle();

        issue(1'b1, 2'd2, 1'b0, 8'h10, 32'h8000_00F0);
        lit("store W ack", 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 8'h10, 32'h0);
        lit("LB @10", 32'hFFFF_FFF0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 8'h13, 32'h0);
        lit("LBU @13", 32'h0000_0080, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 8'h12, 32'h0);
        lit("LH @12", 32'hFFFF_8000, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 8'h12, 32'h0);
        lit("LHU @12", 32'h0000_8000, 1'b0);
        idle();

        issue(1'b1, 2'd1, 1'b0, 8'h06, 32'h1234_ABCD);
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0);
        lit("LW @04 after SH", 32'hABCD_0000, 1'b0);
        idle();

        issue(1'b0, 2'd1, 1'b0, 8'h01, 32'h0);
        lit("LH misaligned", 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 8'h02, 32'hDEAD_BEEF);
        lit("SW misaligned", 32'h0, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 8'h04, 32'hFFFF_FFFF);
        lit("size 11", 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 8'h00, 32'h0);
        lit("LW @00 unchanged", 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0);
        lit("LW @04 unchanged", 32'hABCD_0000, 1'b0);
        idle();
        check("valid drops", 32'(rsp_valid), 32'd0);
        check("data holds", rsp_rdata, 32'hABCD_0000);

        issue(1'b1, 2'd0, 1'b0, 8'h20, 32'hFFFF_FF5A);
        lit("SB b2b", 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 8'h20, 32'h0);
        lit("LBU b2b", 32'h0000_005A, 1'b0);
        idle();

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_sweep("restarted sweep length");
        issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        lit("LW @10 cleared", 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0);
        lit("LW @04 cleared", 32'h0, 1'b0);
        idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
